// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Brief    : Shared word format, frame size, state encoding and index helper
//             for the 32-point FFT datapath.
//  Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int I_DEF = 19;
    localparam int F_DEF = 11;
    localparam int N_DEF = 32;
    localparam int W     = I_DEF + F_DEF;
    localparam int LOG2N = $clog2(N_DEF);

    typedef logic [0:0] state_t;
    localparam state_t c_IDLE   = 1'b0;
    localparam state_t c_STREAM = 1'b1;

    // Reverses the low nbits of idx; bits above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < nbits) begin
                r[nbits-1-b] = idx[b];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_out_serializer
//  Brief    : Snapshots a parallel FFT result frame and streams it out one
//             complex sample per cycle over a valid/ready handshake.
//  Revision : 1.0
// ============================================================================
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int I      = I_DEF,
    parameter int F      = F_DEF,
    parameter int N      = N_DEF,
    parameter int BITREV = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CAP,
    input  logic [N*(I+F)-1:0]       IN_R_BUS,
    input  logic [N*(I+F)-1:0]       IN_I_BUS,
    input  logic                     O_READY,
    output logic                     O_VALID,
    output logic [I+F-1:0]           O_R,
    output logic [I+F-1:0]           O_I,
    output logic [$clog2(N)-1:0]     O_IDX,
    output logic                     O_LAST,
    output logic                     BUSY,
    output logic                     OVERRUN
);

    localparam int c_W     = I + F;
    localparam int c_LOG2N = $clog2(N);
    localparam logic [c_LOG2N-1:0] c_LAST_IDX = c_LOG2N'(N - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_LOG2N-1:0]   r_count;
    logic [c_LOG2N-1:0]   w_count_nxt;
    logic [c_LOG2N-1:0]   w_ord;
    logic                 w_xfer;
    logic                 w_cap_en;
    logic                 w_load;
    logic                 w_valid_nxt;
    logic                 w_last_nxt;
    logic                 w_ovr_nxt;

    logic [c_W-1:0]       r_bank_r [N];
    logic [c_W-1:0]       r_bank_i [N];
    logic [c_W-1:0]       w_elem_r;
    logic [c_W-1:0]       w_elem_i;

    logic                 r_valid;
    logic                 r_last;
    logic                 r_ovr;
    logic [c_W-1:0]       r_o_r;
    logic [c_W-1:0]       r_o_i;
    logic [c_LOG2N-1:0]   r_o_idx;

    assign w_xfer = r_valid & O_READY;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_cap_en    = 1'b0;
        w_load      = 1'b0;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_ovr_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (CAP) begin
                    w_state_nxt = c_STREAM;
                    w_count_nxt = '0;
                    w_cap_en    = 1'b1;
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (c_LAST_IDX == '0);
                end
            end
            c_STREAM: begin
                if (w_xfer && (r_count == c_LAST_IDX)) begin
                    // A capture landing on the final transfer chains frames with no bubble.
                    if (CAP) begin
                        w_count_nxt = '0;
                        w_cap_en    = 1'b1;
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = (c_LAST_IDX == '0);
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end
                end else begin
                    if (w_xfer) begin
                        w_count_nxt = r_count + 1'b1;
                        w_load      = 1'b1;
                        w_last_nxt  = ((r_count + 1'b1) == c_LAST_IDX);
                    end
                    w_ovr_nxt = CAP;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    generate
        if (BITREV != 0) begin : g_bitrev
            assign w_ord = c_LOG2N'(bitrev(32'(w_count_nxt), c_LOG2N));
        end else begin : g_natural
            assign w_ord = w_count_nxt;
        end
    endgenerate

    // On capture the bank is being written this edge, so element 0 comes straight from the bus.
    assign w_elem_r = w_cap_en ? IN_R_BUS[0 +: c_W] : r_bank_r[w_ord];
    assign w_elem_i = w_cap_en ? IN_I_BUS[0 +: c_W] : r_bank_i[w_ord];

    always_ff @(posedge CLK) begin
        if (w_cap_en) begin
            for (int k = 0; k < N; k++) begin
                r_bank_r[k] <= IN_R_BUS[k*c_W +: c_W];
                r_bank_i[k] <= IN_I_BUS[k*c_W +: c_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ovr   <= 1'b0;
            r_o_r   <= '0;
            r_o_i   <= '0;
            r_o_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_ovr   <= w_ovr_nxt;
            if (w_load) begin
                r_o_r   <= w_elem_r;
                r_o_i   <= w_elem_i;
                r_o_idx <= w_ord;
            end
        end
    end

    assign O_VALID = r_valid;
    assign O_R     = r_o_r;
    assign O_I     = r_o_i;
    assign O_IDX   = r_o_idx;
    assign O_LAST  = r_last;
    assign BUSY    = (r_state == c_STREAM);
    assign OVERRUN = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_out_serializer
//  Brief    : Directed self-checking bench for fft_out_serializer, natural
//             and bit-reversed read order.
//  Revision : 1.0
// ============================================================================
module tb_fft_out_serializer;

    localparam int c_W = 30;
    localparam int c_N = 32;

    logic             CLK = 1'b0;
    logic [c_N*c_W-1:0] bus_r, bus_i;

    logic rst0, cap0, rdy0, rst1, cap1, rdy1;
    logic             v0, l0, b0, o0, v1, l1, b1, o1;
    logic [c_W-1:0]   r0, i0, r1, i1;
    logic [4:0]       x0, x1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fft_out_serializer #(.I(19), .F(11), .N(32), .BITREV(0)) dut0 (
        .CLK(CLK), .RST(rst0), .CAP(cap0), .IN_R_BUS(bus_r), .IN_I_BUS(bus_i),
        .O_READY(rdy0), .O_VALID(v0), .O_R(r0), .O_I(i0), .O_IDX(x0),
        .O_LAST(l0), .BUSY(b0), .OVERRUN(o0));

    fft_out_serializer #(.I(19), .F(11), .N(32), .BITREV(1)) dut1 (
        .CLK(CLK), .RST(rst1), .CAP(cap1), .IN_R_BUS(bus_r), .IN_I_BUS(bus_i),
        .O_READY(rdy1), .O_VALID(v1), .O_R(r1), .O_I(i1), .O_IDX(x1),
        .O_LAST(l1), .BUSY(b1), .OVERRUN(o1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < c_N; k++) begin
            bus_r[k*c_W +: c_W] = c_W'(k) << 11;
            bus_i[k*c_W +: c_W] = -(c_W'(k) << 11);
        end
    endtask

    function automatic logic [4:0] rev5(input logic [4:0] s);
        return {s[0], s[1], s[2], s[3], s[4]};
    endfunction

    int         e, stalls, vcyc, guard;
    logic [c_W-1:0] neg;

    initial begin
        rst0 = 1; cap0 = 1; rdy0 = 1; rst1 = 1; cap1 = 1; rdy1 = 1;
        load_ramp();

        // 1: reset held with CAP asserted
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_valid", {62'd0, v0, v1}, 64'd0);
            check("rst_busy",  {62'd0, b0, b1}, 64'd0);
            check("rst_data",  {r0 | i0, 5'd0} | {29'd0, x0}, 64'd0);
            check("rst_flags", {62'd0, l0, o0}, 64'd0);
        end
        rst0 = 0; cap0 = 0; rst1 = 0; cap1 = 0;
        tick();

        // 2: full ramp frame, always ready
        cap0 = 1; tick(); cap0 = 0;
        for (int k = 0; k < c_N; k++) begin
            neg = -(c_W'(k) << 11);
            check("s2_valid", 64'(v0), 64'd1);
            check("s2_idx",   64'(x0), 64'(k));
            check("s2_r",     64'(r0), 64'(c_W'(k) << 11));
            check("s2_i",     64'(i0), 64'(neg));
            check("s2_last",  64'(l0), 64'(k == 31));
            tick();
        end
        check("s2_end_valid", 64'(v0), 64'd0);
        check("s2_end_busy",  64'(b0), 64'd0);

        // 3: backpressure for 3 cycles at index 5
        cap0 = 1; tick(); cap0 = 0;
        e = 0; stalls = 0; vcyc = 0; guard = 0;
        while (e < c_N && guard < 60) begin
            guard++;
            check("s3_valid", 64'(v0), 64'd1);
            check("s3_idx",   64'(x0), 64'(e));
            check("s3_r",     64'(r0), 64'(c_W'(e) << 11));
            if (v0) vcyc++;
            if (e == 5 && stalls < 3) begin
                rdy0 = 0; stalls++;
            end else begin
                rdy0 = 1; e++;
            end
            tick();
        end
        rdy0 = 1;
        check("s3_guard",   64'(guard < 60), 64'd1);
        check("s3_vcycles", 64'(vcyc), 64'd35);
        check("s3_end_valid", 64'(v0), 64'd0);

        // 4: CAP while streaming at index 10 with all-ones bus
        cap0 = 1; tick(); cap0 = 0;
        for (int k = 0; k < c_N; k++) begin
            check("s4_idx", 64'(x0), 64'(k));
            check("s4_r",   64'(r0), 64'(c_W'(k) << 11));
            check("s4_ovr", 64'(o0), 64'(k == 11));
            if (k == 10) begin
                bus_r = '1; bus_i = '1; cap0 = 1;
            end else begin
                cap0 = 0;
            end
            // 5: CAP coincident with the final transfer
            if (k == 31) begin
                for (int j = 0; j < c_N; j++) begin
                    bus_r[j*c_W +: c_W] = c_W'(1);
                    bus_i[j*c_W +: c_W] = c_W'(1);
                end
                check("s5_last", 64'(l0), 64'd1);
                cap0 = 1;
            end
            tick();
        end
        cap0 = 0;
        check("s5_valid", 64'(v0), 64'd1);
        check("s5_idx",   64'(x0), 64'd0);
        check("s5_r",     64'(r0), 64'd1);
        check("s5_i",     64'(i0), 64'd1);
        check("s5_ovr",   64'(o0), 64'd0);
        check("s5_busy",  64'(b0), 64'd1);
        guard = 0;
        while (v0 && guard < 40) begin
            guard++;
            tick();
        end
        check("s5_drain", 64'(guard), 64'd32);

        // 6: bit-reversed order, reset at the 12th sample
        load_ramp();
        cap1 = 1; tick(); cap1 = 0;
        for (int s = 0; s < 12; s++) begin
            check("s6_valid", 64'(v1), 64'd1);
            check("s6_idx",   64'(x1), 64'(rev5(5'(s))));
            check("s6_r",     64'(r1), 64'(c_W'(rev5(5'(s))) << 11));
            if (s == 11) rst1 = 1;
            tick();
        end
        rst1 = 0;
        check("s6_rst_valid", 64'(v1), 64'd0);
        check("s6_rst_busy",  64'(b1), 64'd0);
        check("s6_rst_idx",   64'(x1), 64'd0);
        cap1 = 1; tick(); cap1 = 0;
        check("s6_re_valid", 64'(v1), 64'd1);
        check("s6_re_idx",   64'(x1), 64'd0);
        tick();
        check("s6_re_idx1",  64'(x1), 64'd16);
        check("s6_re_r1",    64'(r1), 64'(c_W'(16) << 11));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
